// File: rtl/usb_token_rx.sv
// Byte-serial USB token receiver: PID/complement check, CRC5 residual, address/endpoint qualify, SOF decode.
// Define USB_TOKEN_PING_EN to accept PING (0100) as a token; otherwise PING packets are discarded.
module usb_token_rx #(
    parameter int NUM_ENDP    = 4,
    parameter bit ADDR_FILTER = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    input  logic [6:0]  dev_addr,
    output logic        token_valid,
    output logic [3:0]  token_pid,
    output logic [3:0]  token_endp,
    output logic        sof_valid,
    output logic [10:0] frame_no,
    output logic        pid_err,
    output logic        crc_err,
    output logic        ep_err
);

    typedef enum logic [2:0] {IDLE, PID, B1, B2, TAIL, DISCARD} state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_PING  = 4'b0100;
    localparam logic [4:0] CRC_RESIDUAL = 5'b01100;
    localparam logic [4:0] NUM_ENDP_W   = 5'(NUM_ENDP);
`ifdef USB_TOKEN_PING_EN
    localparam bit PING_OK = 1'b1;
`else
    localparam bit PING_OK = 1'b0;
`endif

    // x^5+x^2+1, bits consumed LSB first as they appeared on the wire
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in, input logic [7:0] din);
        logic [4:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ din[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic [3:0]  pid_q, pid_d;
    logic [7:0]  b1_q, b1_d;
    logic [2:0]  endp_hi_q, endp_hi_d;
    logic [4:0]  crc_q, crc_d;
    logic        token_valid_q, token_valid_d;
    logic [3:0]  token_pid_q, token_pid_d;
    logic [3:0]  token_endp_q, token_endp_d;
    logic        sof_valid_q, sof_valid_d;
    logic [10:0] frame_no_q, frame_no_d;
    logic        pid_err_q, pid_err_d;
    logic        crc_err_q, crc_err_d;
    logic        ep_err_q, ep_err_d;

    logic       pid_comp_ok, pid_is_token;
    logic [6:0] rx_addr;
    logic [3:0] rx_endp;

    assign pid_comp_ok  = (rx_data[7:4] == ~rx_data[3:0]);
    assign pid_is_token = (rx_data[3:0] == PID_OUT) || (rx_data[3:0] == PID_IN) ||
                          (rx_data[3:0] == PID_SETUP) || (rx_data[3:0] == PID_SOF) ||
                          (PING_OK && (rx_data[3:0] == PID_PING));
    assign rx_addr = b1_q[6:0];
    assign rx_endp = {endp_hi_q, b1_q[7]};

    always_comb begin
        state_d       = state_q;
        armed_d       = ~rx_active;
        pid_d         = pid_q;
        b1_d          = b1_q;
        endp_hi_d     = endp_hi_q;
        crc_d         = crc_q;
        token_pid_d   = token_pid_q;
        token_endp_d  = token_endp_q;
        frame_no_d    = frame_no_q;
        token_valid_d = 1'b0;
        sof_valid_d   = 1'b0;
        pid_err_d     = 1'b0;
        crc_err_d     = 1'b0;
        ep_err_d      = 1'b0;
        case (state_q)
            // armed_q keeps a packet that was already in flight at reset from being picked up mid-way
            IDLE: if (rx_active && armed_q) state_d = PID;
            PID: begin
                if (rx_error)       state_d = DISCARD;
                else if (!rx_active) state_d = IDLE;
                else if (rx_valid) begin
                    if (!pid_comp_ok) begin
                        pid_err_d = 1'b1;
                        state_d   = DISCARD;
                    end else if (pid_is_token) begin
                        pid_d   = rx_data[3:0];
                        crc_d   = 5'b11111;
                        state_d = B1;
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            B1: begin
                if (rx_error)       state_d = DISCARD;
                else if (!rx_active) state_d = IDLE;
                else if (rx_valid) begin
                    b1_d    = rx_data;
                    crc_d   = crc5_byte(crc_q, rx_data);
                    state_d = B2;
                end
            end
            B2: begin
                if (rx_error)       state_d = DISCARD;
                else if (!rx_active) state_d = IDLE;
                else if (rx_valid) begin
                    endp_hi_d = rx_data[2:0];
                    crc_d     = crc5_byte(crc_q, rx_data);
                    state_d   = TAIL;
                end
            end
            TAIL: begin
                if (rx_error) state_d = DISCARD;
                else if (!rx_active) begin
                    state_d = IDLE;
                    if (crc_q != CRC_RESIDUAL) begin
                        crc_err_d = 1'b1;
                    end else if (pid_q == PID_SOF) begin
                        sof_valid_d = 1'b1;
                        frame_no_d  = {endp_hi_q, b1_q};
                    end else if (!ADDR_FILTER || (rx_addr == dev_addr)) begin
                        if ({1'b0, rx_endp} >= NUM_ENDP_W) begin
                            ep_err_d = 1'b1;
                        end else begin
                            token_valid_d = 1'b1;
                            token_pid_d   = pid_q;
                            token_endp_d  = rx_endp;
                        end
                    end
                end else if (rx_valid) state_d = DISCARD;
            end
            DISCARD: if (!rx_active) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            armed_q       <= 1'b0;
            pid_q         <= 4'b0000;
            b1_q          <= 8'h00;
            endp_hi_q     <= 3'b000;
            crc_q         <= 5'b11111;
            token_valid_q <= 1'b0;
            token_pid_q   <= 4'b0000;
            token_endp_q  <= 4'b0000;
            sof_valid_q   <= 1'b0;
            frame_no_q    <= 11'd0;
            pid_err_q     <= 1'b0;
            crc_err_q     <= 1'b0;
            ep_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            pid_q         <= pid_d;
            b1_q          <= b1_d;
            endp_hi_q     <= endp_hi_d;
            crc_q         <= crc_d;
            token_valid_q <= token_valid_d;
            token_pid_q   <= token_pid_d;
            token_endp_q  <= token_endp_d;
            sof_valid_q   <= sof_valid_d;
            frame_no_q    <= frame_no_d;
            pid_err_q     <= pid_err_d;
            crc_err_q     <= crc_err_d;
            ep_err_q      <= ep_err_d;
        end
    end

    assign token_valid = token_valid_q;
    assign token_pid   = token_pid_q;
    assign token_endp  = token_endp_q;
    assign sof_valid   = sof_valid_q;
    assign frame_no    = frame_no_q;
    assign pid_err     = pid_err_q;
    assign crc_err     = crc_err_q;
    assign ep_err      = ep_err_q;

endmodule

// File: doc/usb_token_rx.md
Name: usb_token_rx

Overview:
- Byte-serial USB token packet receiver. Sits between the SIE byte deserialiser (NRZI/bit-unstuffing upstream) and the endpoint/control logic.
- Validates the PID and its complement, checks CRC5, and matches the device address.
- Qualifies endpoints against a parametrised endpoint count and decodes SOF frame numbers.
- Generalises the fixed token record (pidx, pid, addr, endp, crc5) into a checked, parametrised, sequential receiver.

Parameters:
NUM_ENDP, 4, number of implemented endpoints (1..16); endp >= NUM_ENDP yields ep_err instead of token_valid.
ADDR_FILTER, 1, 1 = only tokens with addr == dev_addr produce token_valid; 0 = promiscuous.

Ports:
clk  in  1  system clock.
reset_n  in  1  synchronous reset, active low.
rx_active  in  1  high for the duration of a received packet; falling edge = EOP.
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte (LSB = first bit on wire).
rx_data  in  8  received byte.
rx_error  in  1  bit-stuff/PHY error strobe from upstream.
dev_addr  in  7  current device address (0 after bus reset).
token_valid  out  1  one-cycle pulse: accepted OUT/IN/SETUP token.
token_pid  out  4  PID of last accepted token (OUT=0001, IN=1001, SETUP=1101, PING=0100).
token_endp  out  4  endpoint of last accepted token.
sof_valid  out  1  one-cycle pulse: valid SOF received.
frame_no  out  11  frame number of last valid SOF.
pid_err  out  1  one-cycle pulse: PID check failed.
crc_err  out  1  one-cycle pulse: CRC5 residual mismatch.
ep_err  out  1  one-cycle pulse: address matched, endpoint not implemented.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; all pulses 0; token_pid=0000, token_endp=0, frame_no=0. Reset mid-packet aborts the packet silently; the rest of that packet is ignored until rx_active low.
- Byte format: byte0 = {~pid, pid}; byte1 = {endp[0], addr[6:0]}; byte2 = {crc5[4:0], endp[3:1]}. For SOF, the 11 bits of bytes 1-2 are frame_no[10:0].
- CRC5: polynomial x^5+x^2+1, register preset 11111. Processed serially LSB-first over all 16 bits of bytes 1-2 (two bytes per packet, 8 bit-steps combinational per byte). A valid packet leaves residual 01100.
- FSM states: IDLE, PID, B1, B2, TAIL, DISCARD.
  - IDLE -> PID on rx_active=1.
  - PID: on rx_valid, check byte0[7:4] == ~byte0[3:0] and that the PID is a token type (OUT/IN/SETUP/SOF, plus PING if enabled).
    - Fail: pid_err pulse if the complement mismatched; any non-token PID goes to DISCARD silently (data/handshake belong to other blocks).
    - Pass: go to B1.
  - B1 -> B2 on rx_valid.
  - B2 -> TAIL on rx_valid.
  - TAIL: a further rx_valid means length error -> DISCARD, no pulses.
  - On EOP (rx_active low) in TAIL, evaluate in that cycle and register the result, so pulses appear exactly 1 clk after the first cycle rx_active is sampled low. Evaluation order:
    - crc_err if residual != 01100;
    - else SOF -> sof_valid and update frame_no (no address filter);
    - else if ADDR_FILTER and addr != dev_addr -> no pulse;
    - else if endp >= NUM_ENDP -> ep_err;
    - else token_valid, updating token_pid/token_endp.
  - EOP in PID/B1/B2 (short packet) -> IDLE, no pulses.
  - rx_error in any non-IDLE state -> DISCARD.
  - DISCARD -> IDLE when rx_active=0.
- token_pid/token_endp/frame_no hold until the next accepted event.
- At most one pulse output is high per cycle.
- dev_addr is sampled at EOP evaluation, so an address change mid-packet applies to that packet.
- rx_valid while rx_active=0 is ignored.

Optional Feature:
- USB_TOKEN_PING_EN defined: PID 0100 (PING) is accepted as a token with OUT-style format, producing token_valid with token_pid=0100.
- Undefined: PING goes to DISCARD with no pulse, and the block is USB 1.1 only.

Test Plan:
- SETUP, dev_addr=0: bytes 2D,00,10 then EOP -> token_valid=1 one clk after EOP, token_pid=1101, token_endp=0; no error pulses.
- Corrupt CRC: bytes 2D,00,11 -> crc_err=1, token_valid=0, token_pid unchanged.
- PID complement error: byte0=2C -> pid_err pulse, rest of packet discarded, no further pulses.
- Address filter: IN 69,00,10 with dev_addr=5 -> no pulses. Same packet, dev_addr=0, NUM_ENDP=1 -> token_valid. IN to endp 3 (bench-computed CRC) with NUM_ENDP=2 -> ep_err.
- SOF frame 0x123 with bench-model CRC, any dev_addr -> sof_valid, frame_no=0x123. Then 4-byte SOF -> no pulse, frame_no stays 0x123.
- reset_n low after byte1 of a SETUP -> no pulse; a following valid IN 69,00,10 -> token_valid. PING 4B,00,10 -> token_valid only with USB_TOKEN_PING_EN.
